exec_sequencer: RTL
===================

# exec_sequencer

Execution sequencer for the processor core: it produces the single-cycle clock-enable that advances the control unit and datapath. The core then runs from the board clock instead of a fabric-divided clock. It supports free-run at a divided rate, single-step from the debounced push-button, and halt on request from the control unit. It sits between the debounce block, the board switches, and the control unit / datapath pair.

## Interface
- `DIV`, default 500000: clk cycles between enable pulses in RUN; 100 Hz at 50 MHz; legal range ≥ 2.
- `clk`  in  1  board clock, 50 MHz; all logic on the rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `run_sw`  in  1  level; 1 selects free-run, 0 selects step mode.
- `step_btn`  in  1  debounced button level, synchronous to clk.
- `halt_req`  in  1  level from the control unit; HALT instruction decoded.
- `resume`  in  1  level; leaves HALTED on its rising edge.
- `cpu_en`  out  1  one-cycle advance strobe to the control unit and datapath.
- `state`  out  2  current FSM state encoding.
- `halted`  out  1  high while in HALTED.
- `cycle_cnt`  out  32  count of issued `cpu_en` pulses (see Configuration).

## Operation
- Reset values: state=IDLE, `cpu_en`=0, `halted`=0, `cycle_cnt`=0, divider=0, edge registers=0.
- Rising-edge detection:
  - Registered previous copies of `step_btn` and `resume`.
  - Edge = cur & ~prev.
  - Edge registers reset to 0, so a button held through reset release counts as an edge.
- IDLE: `cpu_en`=0; divider held at 0.
  - `run_sw`=1 → RUN.
  - Else a step edge → STEP; `cpu_en`=1 on the next cycle.
- RUN: divider counts 0..DIV-1.
  - At DIV-1 the divider wraps to 0 and `cpu_en` pulses.
  - `run_sw`=0 → IDLE; divider cleared; no pulse that cycle.
- STEP: exactly one `cpu_en` pulse is issued.
  - The FSM stays in STEP until `step_btn`=0, then → IDLE.
  - Holding the button never produces a second pulse.
- HALTED: `cpu_en`=0; `halted`=1; step edges and `run_sw` are ignored.
  - A `resume` edge → IDLE. The FSM can re-enter RUN only after that.
- Priority, from IDLE, RUN or STEP:
  - `halt_req`=1 → HALTED; halt wins over everything.
  - Otherwise `run_sw` wins over a step edge.
  - A simultaneous divider terminal count and `halt_req` produces no pulse.
- `halt_req` held high after `resume`: the FSM returns to HALTED the next cycle. The control unit must drop it.
- Divider width is $clog2(DIV). Compare against DIV-1; no modulo arithmetic.

## Timing
- All outputs are registered; no combinational input→output path.
- Step edge sampled at cycle N (IDLE) → `cpu_en` high in cycle N+1 only.
- RUN entered at cycle N → first `cpu_en` at cycle N+DIV, then every DIV cycles.
- `halt_req` sampled at cycle N → `halted`=1 and `cpu_en`=0 from N+1.
- `state` and `halted` update in the same cycle as the transition register.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). A `cpu_en` pulse in flight is truncated.

## Configuration
- Macro `EXEC_CYCLE_COUNT_EN`.
- Defined:
  - `cycle_cnt` increments by 1 in each cycle `cpu_en`=1.
  - It wraps 0xFFFFFFFF→0.
  - It is cleared only by reset.
- Undefined: `cycle_cnt` is tied to 0 and no counter flops are synthesised.

## Structure
- Shared package `exec_pkg`:
  - State type: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11.
  - Default DIV constant.
- Sub-module `tick_divider`:
  - Inputs: `clk`, `n_reset`, `clear`, `enable`.
  - Parameter: `DIV`.
  - Output: `tick` high for one cycle at DIV-1.
  - Instantiated once, with `clear` driven when not in RUN.
- FSM, edge detectors and the optional counter live in `exec_sequencer`.

## Test plan
- DIV=4, reset released, `run_sw`=1 at cycle 10 → `cpu_en` pulses at cycles 14, 18, 22. With the macro on, `cycle_cnt`=3 at cycle 23.
- Step mode: hold `step_btn` for 20 cycles → exactly one `cpu_en` pulse, one cycle after the edge. The FSM returns to IDLE one cycle after release. A second press gives a second pulse.
- RUN with DIV=4: `halt_req` asserted in the same cycle as the terminal count → no pulse and `halted`=1 next cycle. `run_sw` toggles and step presses cause no pulses. A `resume` edge with `halt_req`=0 → state=IDLE.
- Simultaneous step edge and `run_sw`=1 in IDLE → state=RUN and no immediate pulse. The first pulse comes DIV cycles later.
- `n_reset` pulsed low mid-RUN while `cpu_en`=1 → `cpu_en`, `halted` and `cycle_cnt` are 0 immediately and state=IDLE.
- Macro undefined, 10 step pulses → `cycle_cnt` stays 0 throughout.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execution sequencer: state encoding and default divider.
package exec_pkg;

  localparam int unsigned DIV_DEFAULT = 500000;
  localparam int unsigned STATE_W     = 2;
  localparam int unsigned CNT_W       = 32;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_RUN    = 2'b01;
  localparam state_t ST_STEP   = 2'b10;
  localparam state_t ST_HALTED = 2'b11;

endpackage : exec_pkg

// File: rtl/exec_sequencer_tick_divider.sv
// Free-running divider: counts 0..DIV-1 while enabled and flags the terminal count.
module tick_divider
  import exec_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned     DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);

  // Divider counter; wraps at the terminal count, held at zero while cleared.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + DIV_W'(1);
    end
  end

  assign tick = enable & ~clear & w_last;

endmodule : tick_divider

// File: rtl/exec_sequencer.sv
// Execution sequencer: produces the one-cycle cpu_en strobe in free-run,
// single-step and halted modes. Optional macro EXEC_CYCLE_COUNT_EN enables
// the issued-pulse counter on cycle_cnt; otherwise cycle_cnt is tied to 0.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             resume,
  output logic             cpu_en,
  output logic [STATE_W-1:0] state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_cpu_en;
  logic   w_cpu_en_nxt;
  logic   r_halted;
  logic   r_step_prev;
  logic   r_resume_prev;
  logic   w_step_edge;
  logic   w_resume_edge;
  logic   w_tick;
  logic   w_in_run;

  assign w_step_edge   = step_btn & ~r_step_prev;
  assign w_resume_edge = resume & ~r_resume_prev;
  assign w_in_run      = (r_state == ST_RUN);

  tick_divider #(
    .DIV (DIV)
  ) u_tick_divider (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (~w_in_run),
    .enable  (w_in_run),
    .tick    (w_tick)
  );

  // Previous-value registers for rising-edge detection of step and resume.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_step_prev   <= 1'b0;
      r_resume_prev <= 1'b0;
    end else begin
      r_step_prev   <= step_btn;
      r_resume_prev <= resume;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= ST_IDLE;
      r_cpu_en <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_en <= w_cpu_en_nxt;
      r_halted <= (w_state_nxt == ST_HALTED);
    end
  end

  // Next state and strobe: halt beats run, run beats a step edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_cpu_en_nxt = 1'b0;
    case (r_state)
      ST_HALTED: begin
        if (w_resume_edge) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        if (halt_req) begin
          w_state_nxt = ST_HALTED;
        end else if (run_sw) begin
          w_state_nxt  = ST_RUN;
          w_cpu_en_nxt = w_in_run & w_tick;
        end else if (r_state == ST_IDLE) begin
          if (w_step_edge) begin
            w_state_nxt  = ST_STEP;
            w_cpu_en_nxt = 1'b1;
          end
        end else if (r_state == ST_STEP) begin
          if (!step_btn) begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign cpu_en = r_cpu_en;
  assign state  = r_state;
  assign halted = r_halted;

`ifdef EXEC_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  // Count of issued cpu_en pulses; wraps naturally, cleared only by reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cycle_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(r_cpu_en);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`else
  assign cycle_cnt = '0;
`endif

endmodule : exec_sequencer
